// File: rtl/result_router.sv
// result_router: round-robin collection of worker results into one FIFO.
// The FIFO head is routed by dest_option[1]. Operand results go to the
// matching unit (MT) and direct results go to instruction fetch (IF).
module result_router #(
  parameter int NUM_WORKERS         = 4,
  parameter int WORKER_RESULT_WIDTH = 60,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic                                       CLK,
  input  logic                                       RST,
  input  logic [NUM_WORKERS-1:0]                     WR_VALID,
  input  logic [NUM_WORKERS*WORKER_RESULT_WIDTH-1:0] WR_DATA,
  output logic [NUM_WORKERS-1:0]                     WR_READY,
  output logic                                       MT_VALID,
  output logic [WORKER_RESULT_WIDTH-1:0]             MT_DATA,
  input  logic                                       MT_READY,
  output logic                                       IF_VALID,
  output logic [WORKER_RESULT_WIDTH-1:0]             IF_DATA,
  input  logic                                       IF_READY,
  output logic [$clog2(FIFO_DEPTH):0]                OCCUPANCY
);

  localparam int W    = WORKER_RESULT_WIDTH;
  localparam int IDXW = $clog2(NUM_WORKERS);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int OW   = PW + 1;

  logic [IDXW-1:0]        rr_q, rr_d;
  logic [PW-1:0]          rd_q, rd_d, wr_q, wr_d;
  logic [OW-1:0]          occ_q, occ_d;
  logic [W-1:0]           mem_q [FIFO_DEPTH];

  logic [NUM_WORKERS-1:0] grant;
  logic [IDXW-1:0]        gidx;
  logic                   full, empty, push, pop;
  logic [W-1:0]           head, wdata;

  assign full  = (occ_q == OW'(FIFO_DEPTH));
  assign empty = (occ_q == '0);

  // Round-robin search: first valid worker upward from rr_q+1, wrapping.
  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    gidx  = rr_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_WORKERS; i++) begin
      idx = (int'(rr_q) + i) % NUM_WORKERS;
      if (!found && WR_VALID[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = IDXW'(idx);
      end
    end
  end

  // Intake handshake; a full FIFO refuses even if the head pops this cycle.
  always_comb begin
    WR_READY = (RST || full) ? '0 : grant;
    push     = |(WR_VALID & WR_READY);
    wdata    = WR_DATA[gidx*W +: W];
  end

  // Route the head by dest_option[1]; outputs are forced quiet during reset.
  always_comb begin
    head     = mem_q[rd_q];
    MT_VALID = !RST && !empty && !head[W-1];
    IF_VALID = !RST && !empty &&  head[W-1];
    MT_DATA  = RST ? '0 : head;
    IF_DATA  = RST ? '0 : head;
    pop      = (MT_VALID && MT_READY) || (IF_VALID && IF_READY);
  end

  // Next-state for pointers, occupancy and the round-robin pointer.
  always_comb begin
    rr_d  = push ? gidx : rr_q;
    wr_d  = push ? wr_q + PW'(1) : wr_q;
    rd_d  = pop  ? rd_q + PW'(1) : rd_q;
    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + OW'(1);
    else if (!push && pop) occ_d = occ_q - OW'(1);
  end

  // Control state; async reset empties the FIFO and restarts arbitration.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_q  <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      occ_q <= '0;
    end else begin
      rr_q  <= rr_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      occ_q <= occ_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q] <= wdata;
  end

  assign OCCUPANCY = occ_q;

endmodule

// File: tb/tb_result_router.sv
// Scoreboard bench for result_router: stimulus pushes expected beats,
// a negedge monitor pops and compares on every output handshake.
module tb_result_router;
  localparam int NW = 4;
  localparam int W  = 60;
  localparam int D  = 4;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [NW-1:0]   WR_VALID = '0;
  logic [NW*W-1:0] WR_DATA  = '0;
  logic [NW-1:0]   WR_READY;
  logic            MT_VALID, IF_VALID;
  logic [W-1:0]    MT_DATA, IF_DATA;
  logic            MT_READY = 1'b0;
  logic            IF_READY = 1'b0;
  logic [$clog2(D):0] OCCUPANCY;

  result_router #(.NUM_WORKERS(NW), .WORKER_RESULT_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .CLK(CLK), .RST(RST), .WR_VALID(WR_VALID), .WR_DATA(WR_DATA), .WR_READY(WR_READY),
    .MT_VALID(MT_VALID), .MT_DATA(MT_DATA), .MT_READY(MT_READY),
    .IF_VALID(IF_VALID), .IF_DATA(IF_DATA), .IF_READY(IF_READY), .OCCUPANCY(OCCUPANCY)
  );

  always #5 CLK = ~CLK;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] opt, input logic [31:0] d);
    return {opt, 10'h0, 16'h0, d};
  endfunction

  // Monitor: every output handshake must match the scoreboard head.
  always @(negedge CLK) begin
    if (!RST) begin
      if (MT_VALID && IF_VALID) chk("both_valid", 64'd1, 64'd0);
      if ((MT_VALID && MT_READY) || (IF_VALID && IF_READY)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", MT_DATA);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("mt_data", 64'(MT_DATA), 64'(mon_exp));
          chk("if_data", 64'(IF_DATA), 64'(mon_exp));
          chk("route_if", 64'(IF_VALID), 64'(mon_exp[W-1]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    WR_VALID = '0;
    exp_q.delete();
    tick();
    tick();
    RST = 1'b0;
  endtask

  // Wait (bounded) for worker w to be granted, then let the beat go.
  task automatic wait_acc(input int w);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge CLK);
      if (WR_READY[w]) ok = 1'b1;
    end
    chk("accept", 64'(ok), 64'd1);
    @(posedge CLK);
    #1;
    WR_VALID[w] = 1'b0;
  endtask

  task automatic send(input int w, input logic [W-1:0] b);
    WR_DATA[w*W +: W] = b;
    WR_VALID[w] = 1'b1;
    exp_q.push_back(b);
    wait_acc(w);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge CLK);
      if (exp_q.size() == 0) ok = 1'b1;
    end
    chk("drain", 64'(ok), 64'd1);
    tick();
    chk("drain_occ", 64'(OCCUPANCY), 64'd0);
  endtask

  initial begin
    int ord[5];
    ord = '{1, 2, 3, 0, 1};

    // Reset state, with requests pending.
    WR_VALID = '1;
    #2;
    chk("rst_ready", 64'(WR_READY), 64'd0);
    chk("rst_mt_valid", 64'(MT_VALID), 64'd0);
    chk("rst_if_valid", 64'(IF_VALID), 64'd0);
    chk("rst_mt_data", 64'(MT_DATA), 64'd0);
    chk("rst_occ", 64'(OCCUPANCY), 64'd0);
    do_reset();

    // Single beat from worker 1 to MT.
    MT_READY = 1'b1;
    IF_READY = 1'b1;
    WR_DATA[1*W +: W] = mk(2'b00, 32'h5);
    WR_VALID[1] = 1'b1;
    exp_q.push_back(mk(2'b00, 32'h5));
    @(negedge CLK);
    chk("single_ready", 64'(WR_READY), 64'b0010);
    tick();
    WR_VALID[1] = 1'b0;
    @(negedge CLK);
    chk("single_mt_valid", 64'(MT_VALID), 64'd1);
    chk("single_if_valid", 64'(IF_VALID), 64'd0);
    tick();
    drain();

    // Round-robin with all workers requesting.
    do_reset();
    MT_READY = 1'b1;
    for (int i = 0; i < NW; i++) WR_DATA[i*W +: W] = mk(2'b00, 32'h100 + 32'(i));
    for (int k = 0; k < 5; k++) exp_q.push_back(mk(2'b00, 32'h100 + 32'(ord[k])));
    WR_VALID = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("rr_grant", 64'(WR_READY), 64'd1 << ord[k]);
      tick();
    end
    WR_VALID = '0;
    drain();

    // Full FIFO: 4 accepted, then two blocked offers.
    do_reset();
    MT_READY = 1'b0;
    IF_READY = 1'b0;
    for (int k = 0; k < 4; k++) send(2, mk(2'b00, 32'h300 + 32'(k)));
    chk("full_occ", 64'(OCCUPANCY), 64'd4);
    WR_DATA[2*W +: W] = mk(2'b00, 32'h304);
    WR_DATA[3*W +: W] = mk(2'b00, 32'h305);
    WR_VALID[3:2] = 2'b11;
    repeat (3) begin
      @(negedge CLK);
      chk("full_ready", 64'(WR_READY), 64'd0);
      chk("full_occ_hold", 64'(OCCUPANCY), 64'd4);
    end
    exp_q.push_back(mk(2'b00, 32'h305));
    exp_q.push_back(mk(2'b00, 32'h304));
    tick();
    MT_READY = 1'b1;
    wait_acc(3);
    wait_acc(2);
    drain();

    // Head-of-line blocking: MT head stalls an IF beat behind it.
    do_reset();
    MT_READY = 1'b0;
    IF_READY = 1'b1;
    send(1, mk(2'b00, 32'hA));
    send(2, mk(2'b10, 32'hB));
    repeat (3) begin
      @(negedge CLK);
      chk("hol_if_valid", 64'(IF_VALID), 64'd0);
      chk("hol_mt_valid", 64'(MT_VALID), 64'd1);
    end
    tick();
    MT_READY = 1'b1;
    drain();

    // Simultaneous push and pop at occupancy 2.
    do_reset();
    MT_READY = 1'b0;
    send(0, mk(2'b00, 32'h50));
    send(1, mk(2'b00, 32'h51));
    chk("pp_occ_before", 64'(OCCUPANCY), 64'd2);
    MT_READY = 1'b1;
    WR_DATA[3*W +: W] = mk(2'b00, 32'h53);
    WR_VALID[3] = 1'b1;
    exp_q.push_back(mk(2'b00, 32'h53));
    @(negedge CLK);
    chk("pp_ready", 64'(WR_READY[3]), 64'd1);
    tick();
    WR_VALID[3] = 1'b0;
    MT_READY = 1'b0;
    chk("pp_occ", 64'(OCCUPANCY), 64'd2);
    MT_READY = 1'b1;
    drain();

    // Pointer wrap: 20 beats alternating destinations.
    MT_READY = 1'b1;
    IF_READY = 1'b1;
    for (int k = 0; k < 20; k++)
      send(k % NW, mk((k % 2 != 0) ? 2'b10 : 2'b00, 32'h1000 + 32'(k)));
    drain();

    // Async reset with 3 beats buffered and a request pending.
    MT_READY = 1'b0;
    IF_READY = 1'b0;
    send(1, mk(2'b00, 32'h61));
    send(2, mk(2'b10, 32'h62));
    send(3, mk(2'b00, 32'h63));
    WR_DATA[0 +: W] = mk(2'b00, 32'h60);
    WR_VALID[0] = 1'b1;
    @(negedge CLK);
    chk("pre_rst_mt_valid", 64'(MT_VALID), 64'd1);
    chk("pre_rst_ready", 64'(WR_READY), 64'b0001);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_mt_valid", 64'(MT_VALID), 64'd0);
    chk("arst_if_valid", 64'(IF_VALID), 64'd0);
    chk("arst_ready", 64'(WR_READY), 64'd0);
    chk("arst_occ", 64'(OCCUPANCY), 64'd0);
    exp_q.delete();
    WR_VALID = '0;
    tick();
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_occ", 64'(OCCUPANCY), 64'd0);
    chk("post_rst_mt_valid", 64'(MT_VALID), 64'd0);
    chk("post_rst_if_valid", 64'(IF_VALID), 64'd0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
